// File: rtl/verlet_step_scheduler.sv
// verlet_step_scheduler: sequences one simulation step for a core's chain of
// Verlet nodes: one-hot integration sweep, halo exchange handshake, then
// ITERS red-black constraint-relaxation passes. Counts completed steps and
// flags halo timeouts.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   start          begin one step (honoured only in IDLE)
//   halo_ack       neighbour boundary positions valid (sampled only in HALO)
//   node_en        one-hot integrate enable, node k
//   constrain_mask nodes allowed to latch constrained positions this cycle
//   halo_req       boundary exchange request
//   iter_idx       current relaxation iteration
//   busy           high in every state except IDLE
//   step_done      one-cycle pulse when a step completes
//   step_count     completed steps, wraps at 16 bits
//   halo_err       sticky halo-timeout flag for the current/last step
module verlet_step_scheduler #(
    parameter int unsigned NODES        = 5,
    parameter int unsigned ITERS        = 4,
    parameter int unsigned HALO_TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           halo_ack,
    output logic [NODES-1:0]               node_en,
    output logic [NODES-1:0]               constrain_mask,
    output logic                           halo_req,
    output logic [$clog2(ITERS+1)-1:0]     iter_idx,
    output logic                           busy,
    output logic                           step_done,
    output logic [15:0]                    step_count,
    output logic                           halo_err
);

    localparam int unsigned IW = $clog2(ITERS + 1);
    localparam int unsigned PW = $clog2(NODES);
    localparam int unsigned WW = $clog2(HALO_TIMEOUT + 1);

    // Even-phase mask: bits 0,2,4,...
    function automatic logic [NODES-1:0] even_bits();
        logic [NODES-1:0] m;
        m = '0;
        for (int i = 0; i < int'(NODES); i += 2) begin
            m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [NODES-1:0] EVEN_MASK = even_bits();
    localparam logic [NODES-1:0] ODD_MASK  = ~EVEN_MASK;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INTEGRATE = 3'd1,
        HALO      = 3'd2,
        CONSTRAIN = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [WW-1:0]   r_wait;
    logic            r_odd;

    state_t          w_state_nxt;
    logic [PW-1:0]   w_ptr_nxt;
    logic [WW-1:0]   w_wait_nxt;
    logic            w_odd_nxt;
    logic [IW-1:0]   w_iter_nxt;
    logic            w_err_nxt;
    logic [15:0]     w_cnt_nxt;
    logic [NODES-1:0] w_node_en_nxt;
    logic [NODES-1:0] w_mask_nxt;

    // Next-state, counters, and next output values; outputs are registered
    // from these so each output reflects the state it is observed in.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_wait_nxt    = r_wait;
        w_odd_nxt     = r_odd;
        w_iter_nxt    = iter_idx;
        w_err_nxt     = halo_err;
        w_cnt_nxt     = step_count;
        w_node_en_nxt = '0;
        w_mask_nxt    = '0;

        case (r_state)
            IDLE: begin
                w_iter_nxt = '0;
                if (start) begin
                    w_state_nxt = INTEGRATE;
                    w_ptr_nxt   = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            INTEGRATE: begin
                if (r_ptr == PW'(NODES - 1)) begin
                    w_state_nxt = HALO;
                    w_wait_nxt  = '0;
                end else begin
                    w_ptr_nxt = r_ptr + PW'(1);
                end
            end
            HALO: begin
                if (halo_ack) begin
                    w_state_nxt = CONSTRAIN;
                    w_odd_nxt   = 1'b0;
                    w_iter_nxt  = '0;
                end else if (r_wait == WW'(HALO_TIMEOUT - 1)) begin
                    // Timeout: proceed with stale halo values and flag it.
                    w_state_nxt = CONSTRAIN;
                    w_odd_nxt   = 1'b0;
                    w_iter_nxt  = '0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_wait_nxt = r_wait + WW'(1);
                end
            end
            CONSTRAIN: begin
                if (r_odd) begin
                    w_odd_nxt  = 1'b0;
                    w_iter_nxt = iter_idx + IW'(1);
                    if (iter_idx == IW'(ITERS - 1)) begin
                        w_state_nxt = DONE;
                        w_cnt_nxt   = step_count + 16'd1;
                    end
                end else begin
                    w_odd_nxt = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_state_nxt == INTEGRATE) begin
            w_node_en_nxt = NODES'(1) << w_ptr_nxt;
        end
        if (w_state_nxt == CONSTRAIN) begin
            w_mask_nxt = w_odd_nxt ? ODD_MASK : EVEN_MASK;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_ptr          <= '0;
            r_wait         <= '0;
            r_odd          <= 1'b0;
            node_en        <= '0;
            constrain_mask <= '0;
            halo_req       <= 1'b0;
            iter_idx       <= '0;
            busy           <= 1'b0;
            step_done      <= 1'b0;
            step_count     <= '0;
            halo_err       <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_ptr          <= w_ptr_nxt;
            r_wait         <= w_wait_nxt;
            r_odd          <= w_odd_nxt;
            node_en        <= w_node_en_nxt;
            constrain_mask <= w_mask_nxt;
            halo_req       <= (w_state_nxt == HALO);
            iter_idx       <= w_iter_nxt;
            busy           <= (w_state_nxt != IDLE);
            step_done      <= (w_state_nxt == DONE);
            step_count     <= w_cnt_nxt;
            halo_err       <= w_err_nxt;
        end
    end

endmodule
